writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the RV32I core; sits directly upstream of the register file and drives its write port (i_wr, i_rd, i_write_data).
- Accepts one retiring instruction per handshake from the memory stage and selects the result source (ALU, load data, PC+4).
- Aligns and sign/zero-extends load data, waits for late data-memory responses, and flags misaligned/illegal loads and memory timeouts.
- Registered write outputs also serve as the forwarding source for the execute stage.

Parameters:
- MEM_TIMEOUT, 16: max cycles spent in WAIT_MEM before a timeout trap; 0 disables the timeout.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- i_valid  input  1  memory stage presents an instruction
- o_ready  output  1  stage can accept; equals (state==IDLE)
- i_reg_wr  input  1  instruction writes rd
- i_rd  input  5  destination register
- i_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved
- i_alu_result  input  32  ALU result
- i_pc  input  32  instruction PC
- i_funct3  input  3  load width/sign
- i_addr_lsb  input  2  load byte offset
- i_mem_rvalid  input  1  data-memory read data valid
- i_mem_rdata  input  32  raw word from data memory
- o_wr  output  1  register-file write enable (1-cycle pulse)
- o_rd  output  5  register-file write address
- o_write_data  output  32  register-file write data
- o_retire  output  1  instruction retired this cycle (1-cycle pulse)
- o_trap  output  1  misaligned/illegal load, reserved wb_sel, or timeout (1-cycle pulse)

Behaviour:
- Reset: state=IDLE, timeout counter=0; o_wr, o_rd, o_write_data, o_retire, o_trap all 0. A reset in WAIT_MEM discards the pending load without writing.
- Accept: i_valid && o_ready at edge N.
- Non-load (wb_sel 00/10): o_wr/o_retire high in cycle N+1 only.
  - wb_sel=10: o_write_data = i_pc+4, modulo 2^32 (0xFFFFFFFC -> 0).
- Load (wb_sel=01):
  - If i_mem_rvalid is high in the accept cycle, data is captured and the result appears in N+1.
  - Otherwise go to WAIT_MEM with o_ready=0. The first cycle with i_mem_rvalid=1 captures data; outputs follow next cycle and state returns to IDLE.
  - A WAIT_MEM -> IDLE transition and a new accept never occur in the same cycle.
- Load extraction on i_mem_rdata:
  - 000 LB: byte [8*lsb +: 8], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half [16*lsb[1] +: 16], sign-extended.
  - 101 LHU: same half, zero-extended.
  - 010 LW: full word.
  - 011/110/111: illegal.
- Trap conditions (o_trap pulses in the cycle the result would write; o_wr=0, o_retire=0):
  - LH/LHU with lsb[0]=1.
  - LW with lsb!=0.
  - Illegal funct3.
  - wb_sel=11.
- Misaligned/illegal loads are decided at accept and do not enter WAIT_MEM.
- rd=0 or i_reg_wr=0: o_wr=0, o_rd=0, o_write_data=0; o_retire still pulses.
- When o_wr=0, o_rd and o_write_data are driven 0.
- Timeout (MEM_TIMEOUT>0):
  - Counter resets to 0 on entry to WAIT_MEM and increments each WAIT_MEM cycle without rvalid.
  - On reaching MEM_TIMEOUT: o_trap next cycle, no write, back to IDLE.
  - Late rvalid arriving after that is ignored.
- i_mem_rvalid in IDLE with no load being accepted is ignored.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined: adds output o_instret [63:0], a retired-instruction counter. Reset to 0; +1 on each o_retire pulse; wraps to 0 from 2^64-1.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ALU op, rd=5, alu=0x12345678, accepted edge N -> cycle N+1: o_wr=1, o_rd=5, o_write_data=0x12345678, o_retire=1; cycle N+2: o_wr=0.
- LB, lsb=3, rdata=0x80FF_FFFF, rvalid same cycle -> write 0xFFFFFF80; LBU same -> 0x00000080; LHU lsb=2 rdata=0xBEEF0000 -> 0x0000BEEF.
- LW with rvalid 3 cycles after accept -> o_ready=0 for 3 cycles, then a single write of rdata; no second accept during the wait.
- LW lsb=2 -> o_trap=1, o_wr=0, o_retire=0, o_ready stays 1. MEM_TIMEOUT=4 with no rvalid -> o_trap after 4 WAIT_MEM cycles, then IDLE.
- JAL-style wb_sel=10, pc=0xFFFFFFFC, rd=1 -> write 0x00000000. Same with rd=0 -> o_wr=0, o_retire=1.
- Reset asserted during WAIT_MEM, then rvalid -> no write, o_ready=1 after reset; with WB_INSTRET_EN, 10 retires -> o_instret=10, reset -> 0.

Source files
------------

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Last stage of the RV32I pipeline. Takes one retiring instruction per
// handshake from the memory stage. It picks the result (ALU, aligned load data
// or PC+4) and drives the register-file write port through registered outputs.
// Those registered outputs are also the forwarding source for the execute stage.
//
// Loads whose data-memory response is late park in WAIT_MEM until
// i_mem_rvalid arrives. They abort with a trap if MEM_TIMEOUT cycles pass first.
//
// Parameters
//   MEM_TIMEOUT  maximum WAIT_MEM cycles before a timeout trap (0 = never)
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   i_valid/o_ready handshake with the memory stage (o_ready = state is IDLE)
//   i_reg_wr, i_rd  instruction writes rd / destination register
//   i_wb_sel        00 ALU, 01 load, 10 PC+4, 11 reserved (traps)
//   i_alu_result    ALU result
//   i_pc            instruction PC
//   i_funct3        load width / signedness
//   i_addr_lsb      load byte offset within the word
//   i_mem_rvalid    data-memory read data valid
//   i_mem_rdata     raw data-memory word
//   o_wr/o_rd/o_write_data  register-file write port (1-cycle pulse)
//   o_retire        instruction retired (1-cycle pulse)
//   o_trap          bad load, reserved wb_sel or memory timeout (1-cycle pulse)
//
// Optional feature: define WB_INSTRET_EN to add o_instret[63:0], a free-running
// count of o_retire pulses.
// -----------------------------------------------------------------------------
module writeback_stage #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_reg_wr,
  input  logic [4:0]  i_rd,
  input  logic [1:0]  i_wb_sel,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_pc,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lsb,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wr,
  output logic [4:0]  o_rd,
  output logic [31:0] o_write_data,
  output logic        o_retire,
  output logic        o_trap
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0] o_instret
`endif
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_RSVD = 2'b11;

  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(MEM_TIMEOUT);

  state_t         state, state_next;
  logic [CW-1:0]  cnt, cnt_next;

  // Context of a load that is waiting for its data
  logic           pend_wr, pend_wr_next;
  logic [4:0]     pend_rd, pend_rd_next;
  logic [2:0]     pend_funct3, pend_funct3_next;
  logic [1:0]     pend_lsb, pend_lsb_next;

  logic           wr_next, retire_next, trap_next;
  logic [4:0]     rd_next;
  logic [31:0]    data_next;

  logic           commit, commit_wr;
  logic [4:0]     commit_rd;
  logic [31:0]    commit_data;

  logic           load_sel, f3_illegal, misaligned, accept_trap;

  // Select and extend the addressed byte, half or word of the raw memory word
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lsb);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lsb, 3'b000} +: 8];
    h = word[{lsb[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'd0, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b101:  load_extract = {16'd0, h};
      3'b010:  load_extract = word;
      default: load_extract = 32'd0;
    endcase
  endfunction

  assign o_ready = (state == IDLE);

  // Bad loads are known from funct3 and the offset alone, so they are trapped
  // at accept and never wait for memory
  assign load_sel    = (i_wb_sel == WB_LOAD);
  assign f3_illegal  = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
  assign misaligned  = ((i_funct3[1:0] == 2'b01) && i_addr_lsb[0]) ||
                       ((i_funct3 == 3'b010) && (i_addr_lsb != 2'b00));
  assign accept_trap = (i_wb_sel == WB_RSVD) || (load_sel && (f3_illegal || misaligned));

  // Next-state and next-output logic. The 'commit' set describes the
  // instruction that retires at the coming edge. Writes to x0 or without
  // reg_wr still retire, but they leave the write port at zero.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    pend_wr_next     = pend_wr;
    pend_rd_next     = pend_rd;
    pend_funct3_next = pend_funct3;
    pend_lsb_next    = pend_lsb;
    commit           = 1'b0;
    commit_wr        = 1'b0;
    commit_rd        = 5'd0;
    commit_data      = 32'd0;
    trap_next        = 1'b0;

    case (state)
      IDLE: begin
        if (i_valid) begin
          if (accept_trap) begin
            trap_next = 1'b1;
          end else if (load_sel && !i_mem_rvalid) begin
            state_next       = WAIT_MEM;
            cnt_next         = '0;
            pend_wr_next     = i_reg_wr && (i_rd != 5'd0);
            pend_rd_next     = i_rd;
            pend_funct3_next = i_funct3;
            pend_lsb_next    = i_addr_lsb;
          end else begin
            commit    = 1'b1;
            commit_wr = i_reg_wr && (i_rd != 5'd0);
            commit_rd = i_rd;
            case (i_wb_sel)
              WB_ALU:  commit_data = i_alu_result;
              WB_PC4:  commit_data = i_pc + 32'd4;
              default: commit_data = load_extract(i_mem_rdata, i_funct3, i_addr_lsb);
            endcase
          end
        end
      end
      WAIT_MEM: begin
        if (i_mem_rvalid) begin
          commit      = 1'b1;
          commit_wr   = pend_wr;
          commit_rd   = pend_rd;
          commit_data = load_extract(i_mem_rdata, pend_funct3, pend_lsb);
          state_next  = IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
          if (TIMEOUT_EN && (cnt_next == TIMEOUT_LIMIT)) begin
            trap_next  = 1'b1;
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    wr_next     = commit && commit_wr;
    rd_next     = wr_next ? commit_rd : 5'd0;
    data_next   = wr_next ? commit_data : 32'd0;
    retire_next = commit;
  end

  // State, pending-load context and registered write-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pend_wr      <= 1'b0;
      pend_rd      <= 5'd0;
      pend_funct3  <= 3'd0;
      pend_lsb     <= 2'd0;
      o_wr         <= 1'b0;
      o_rd         <= 5'd0;
      o_write_data <= 32'd0;
      o_retire     <= 1'b0;
      o_trap       <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      pend_wr      <= pend_wr_next;
      pend_rd      <= pend_rd_next;
      pend_funct3  <= pend_funct3_next;
      pend_lsb     <= pend_lsb_next;
      o_wr         <= wr_next;
      o_rd         <= rd_next;
      o_write_data <= data_next;
      o_retire     <= retire_next;
      o_trap       <= trap_next;
    end
  end

`ifdef WB_INSTRET_EN
  // Counts in step with the o_retire pulse it accounts for. It wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_instret <= 64'd0;
    end else if (retire_next) begin
      o_instret <= o_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed and randomized transactions against writeback_stage (MEM_TIMEOUT=4).
// The expected results come from a behavioural model written directly from the
// load/trap/timeout rules. Inputs change and outputs are sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

  localparam int T = 4;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_reg_wr;
  logic [4:0]  i_rd;
  logic [1:0]  i_wb_sel;
  logic [31:0] i_alu_result;
  logic [31:0] i_pc;
  logic [2:0]  i_funct3;
  logic [1:0]  i_addr_lsb;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_wr;
  logic [4:0]  o_rd;
  logic [31:0] o_write_data;
  logic        o_retire;
  logic        o_trap;
`ifdef WB_INSTRET_EN
  logic [63:0] o_instret;
`endif

  int compared   = 0;
  int mismatched = 0;
  longint unsigned model_instret = 0;

  writeback_stage #(.MEM_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_reg_wr     (i_reg_wr),
    .i_rd         (i_rd),
    .i_wb_sel     (i_wb_sel),
    .i_alu_result (i_alu_result),
    .i_pc         (i_pc),
    .i_funct3     (i_funct3),
    .i_addr_lsb   (i_addr_lsb),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_wr         (o_wr),
    .o_rd         (o_rd),
    .o_write_data (o_write_data),
    .o_retire     (o_retire),
    .o_trap       (o_trap)
`ifdef WB_INSTRET_EN
    ,
    .o_instret    (o_instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

`ifdef WB_INSTRET_EN
  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask
`endif

  // Compare the whole write port in an IDLE cycle
  task automatic checkOutput(input string tag, input logic e_wr, input logic [4:0] e_rd,
                             input logic [31:0] e_data, input logic e_retire, input logic e_trap);
    check32({tag, ".wr"},     {31'd0, o_wr},     {31'd0, e_wr});
    check32({tag, ".rd"},     {27'd0, o_rd},     {27'd0, e_rd});
    check32({tag, ".data"},   o_write_data,      e_data);
    check32({tag, ".retire"}, {31'd0, o_retire}, {31'd0, e_retire});
    check32({tag, ".trap"},   {31'd0, o_trap},   {31'd0, e_trap});
    check32({tag, ".ready"},  {31'd0, o_ready},  32'd1);
`ifdef WB_INSTRET_EN
    check64({tag, ".instret"}, o_instret, model_instret);
`endif
  endtask

  // Reference model. d is the WAIT_MEM cycle in which rvalid arrives
  // (0 = already present when the instruction is accepted).
  task automatic model(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lsb,
                       input logic reg_wr, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] rdata, input int d,
                       output logic e_wr, output logic [4:0] e_rd, output logic [31:0] e_data,
                       output logic e_retire, output logic e_trap, output int nwait);
    int unsigned val, part, off;
    bit bad_load;
    off = lsb;
    bad_load = (f3 == 3) || (f3 == 6) || (f3 == 7) ||
               (((f3 == 1) || (f3 == 5)) && (off % 2 == 1)) ||
               ((f3 == 2) && (off != 0));
    e_wr = 0; e_rd = 0; e_data = 0; e_retire = 0; e_trap = 0; nwait = 0; val = 0;
    if ((sel == 3) || ((sel == 1) && bad_load)) begin
      e_trap = 1;
    end else if ((sel == 1) && (d > T)) begin
      nwait  = T;
      e_trap = 1;
    end else begin
      if (sel == 1) nwait = d;
      if (sel == 0) val = alu;
      else if (sel == 2) val = pc + 32'd4;
      else begin
        case (f3)
          3'd0: begin part = (rdata >> (8 * off)) & 255;           val = (part >= 128)   ? part - 256   : part; end
          3'd4: begin part = (rdata >> (8 * off)) & 255;           val = part; end
          3'd1: begin part = (rdata >> (16 * (off / 2))) & 65535;  val = (part >= 32768) ? part - 65536 : part; end
          3'd5: begin part = (rdata >> (16 * (off / 2))) & 65535;  val = part; end
          default: val = rdata;
        endcase
      end
      e_retire = 1;
      if (reg_wr && (rd != 0)) begin
        e_wr   = 1;
        e_rd   = rd;
        e_data = val;
      end
    end
  endtask

  // Runs one instruction from the accept to the quiet cycle after its result.
  // While the load waits for data, i_valid stays high with garbage fields, so
  // an illegal second accept would show up as extra output activity.
  task automatic applyStimulus(input string tag, input logic [1:0] sel, input logic [2:0] f3,
                               input logic [1:0] lsb, input logic reg_wr, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [31:0] pc,
                               input logic [31:0] rdata, input int d, input logic late);
    logic e_wr, e_retire, e_trap;
    logic [4:0] e_rd;
    logic [31:0] e_data;
    int nwait;
    model(sel, f3, lsb, reg_wr, rd, alu, pc, rdata, d, e_wr, e_rd, e_data, e_retire, e_trap, nwait);

    @(negedge clk);
    check32({tag, ".ready_pre"}, {31'd0, o_ready}, 32'd1);
    i_valid      = 1'b1;
    i_wb_sel     = sel;
    i_funct3     = f3;
    i_addr_lsb   = lsb;
    i_reg_wr     = reg_wr;
    i_rd         = rd;
    i_alu_result = alu;
    i_pc         = pc;
    i_mem_rvalid = (sel == 2'b01) ? (d == 0) : 1'($urandom_range(0, 1));
    i_mem_rdata  = ((sel == 2'b01) && (d == 0)) ? rdata : $urandom;
    @(negedge clk);

    for (int k = 1; k <= nwait; k++) begin
      check32({tag, ".ready_wait"}, {31'd0, o_ready}, 32'd0);
      check32({tag, ".wr_wait"},    {31'd0, o_wr},    32'd0);
      i_valid      = 1'b1;
      i_wb_sel     = 2'($urandom_range(0, 3));
      i_funct3     = 3'($urandom_range(0, 7));
      i_addr_lsb   = 2'($urandom_range(0, 3));
      i_reg_wr     = 1'b1;
      i_rd         = 5'($urandom_range(1, 31));
      i_alu_result = $urandom;
      i_pc         = $urandom;
      i_mem_rvalid = (k == d);
      i_mem_rdata  = (k == d) ? rdata : $urandom;
      @(negedge clk);
    end

    i_valid      = 1'b0;
    i_mem_rvalid = late;
    i_mem_rdata  = $urandom;
    if (e_retire) model_instret++;
    checkOutput({tag, ".result"}, e_wr, e_rd, e_data, e_retire, e_trap);
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    checkOutput({tag, ".quiet"}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_instret = 0;
  endtask

  initial begin
    rst          = 1'b1;
    i_valid      = 1'b0;
    i_reg_wr     = 1'b0;
    i_rd         = 5'd0;
    i_wb_sel     = 2'b00;
    i_alu_result = 32'd0;
    i_pc         = 32'd0;
    i_funct3     = 3'd0;
    i_addr_lsb   = 2'd0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Directed cases
    applyStimulus("alu",      2'b00, 3'd0, 2'd0, 1'b1, 5'd5,  32'h12345678, 32'h0, 32'h0,        0, 1'b0);
    applyStimulus("lb",       2'b01, 3'd0, 2'd3, 1'b1, 5'd6,  32'h0, 32'h0, 32'h80FF_FFFF,       0, 1'b0);
    applyStimulus("lbu",      2'b01, 3'd4, 2'd3, 1'b1, 5'd6,  32'h0, 32'h0, 32'h80FF_FFFF,       0, 1'b0);
    applyStimulus("lhu",      2'b01, 3'd5, 2'd2, 1'b1, 5'd7,  32'h0, 32'h0, 32'hBEEF_0000,       0, 1'b0);
    applyStimulus("lh",       2'b01, 3'd1, 2'd0, 1'b1, 5'd7,  32'h0, 32'h0, 32'h1234_8001,       0, 1'b0);
    applyStimulus("lw_late",  2'b01, 3'd2, 2'd0, 1'b1, 5'd8,  32'h0, 32'h0, 32'hCAFE_F00D,       3, 1'b0);
    applyStimulus("lw_mis",   2'b01, 3'd2, 2'd2, 1'b1, 5'd8,  32'h0, 32'h0, 32'h1111_1111,       0, 1'b0);
    applyStimulus("lh_mis",   2'b01, 3'd1, 2'd1, 1'b1, 5'd8,  32'h0, 32'h0, 32'h1111_1111,       0, 1'b0);
    applyStimulus("f3_ill",   2'b01, 3'd6, 2'd0, 1'b1, 5'd8,  32'h0, 32'h0, 32'h1111_1111,       0, 1'b0);
    applyStimulus("timeout",  2'b01, 3'd2, 2'd0, 1'b1, 5'd9,  32'h0, 32'h0, 32'h2222_2222,     100, 1'b1);
    applyStimulus("lw_edge",  2'b01, 3'd2, 2'd0, 1'b1, 5'd9,  32'h0, 32'h0, 32'h3333_4444,       T, 1'b0);
    applyStimulus("jal",      2'b10, 3'd0, 2'd0, 1'b1, 5'd1,  32'h0, 32'hFFFF_FFFC, 32'h0,       0, 1'b0);
    applyStimulus("jal_x0",   2'b10, 3'd0, 2'd0, 1'b1, 5'd0,  32'h0, 32'hFFFF_FFFC, 32'h0,       0, 1'b0);
    applyStimulus("no_regwr", 2'b00, 3'd0, 2'd0, 1'b0, 5'd3,  32'hDEAD_BEEF, 32'h0, 32'h0,       0, 1'b0);
    applyStimulus("rsvd",     2'b11, 3'd0, 2'd0, 1'b1, 5'd3,  32'hDEAD_BEEF, 32'h0, 32'h0,       0, 1'b0);

    // A reset during WAIT_MEM drops the pending load, and the data that arrives later is ignored
    @(negedge clk);
    i_valid    = 1'b1;
    i_wb_sel   = 2'b01;
    i_funct3   = 3'd2;
    i_addr_lsb = 2'd0;
    i_reg_wr   = 1'b1;
    i_rd       = 5'd7;
    i_mem_rvalid = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    check32("rst_wait.ready", {31'd0, o_ready}, 32'd0);
    doReset();
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h5555_AAAA;
    checkOutput("rst_wait.after", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    checkOutput("rst_wait.rvalid", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

`ifdef WB_INSTRET_EN
    for (int n = 0; n < 10; n++)
      applyStimulus("instret_alu", 2'b00, 3'd0, 2'd0, 1'b1, 5'd4, $urandom, 32'h0, 32'h0, 0, 1'b0);
    check64("instret10", o_instret, 64'd10);
    doReset();
    check64("instret_rst", o_instret, 64'd0);
`endif

    // Randomized transactions. Loads dominate, and some delays exceed the timeout.
    for (int n = 0; n < 60; n++) begin
      logic [1:0] sel;
      sel = ($urandom_range(0, 9) < 5) ? 2'b01 : 2'($urandom_range(0, 3));
      applyStimulus("rand", sel, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                    $urandom, $urandom, $urandom, int'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
